ps2_command_decoder: RTL and testbench
======================================

PS2_COMMAND_DECODER -- requirements
Module: ps2_command_decoder

Interface
REQ-001 SHALL have parameter NUM_COLS, default 7, number of board columns (cursor range 0..NUM_COLS-1).
REQ-002 SHALL have parameter PREFIX_TIMEOUT, default 1_000_000, cycles a pending E0/F0 prefix survives without a following byte.
REQ-003 SHALL have port clk  input  1  system clock (50 MHz).
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port received_data  input  8  scan-code byte from the PS2 controller.
REQ-006 SHALL have port received_data_en  input  1  one-cycle strobe marking received_data valid.
REQ-007 SHALL have port drop_pulse  output  1  one-cycle pulse on Enter make (0x5A).
REQ-008 SHALL have port colsel_pulse  output  1  one-cycle pulse on Space make (0x29).
REQ-009 SHALL have port newgame_pulse  output  1  one-cycle pulse on Backspace make (0x66).
REQ-010 SHALL have port cursor  output  3  selected column index, 0..NUM_COLS-1.
REQ-011 SHALL have port column_onehot  output  8  one-hot of cursor, bit cursor set, bit 7 always 0.
REQ-012 SHALL have port key_held  output  1  high while any decoded key is held (make seen, break not yet seen).

Function
REQ-013 SHALL run a parser FSM with states IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 then F0); bytes are consumed only on cycles with received_data_en=1.
REQ-014 SHALL transition IDLE->EXT on E0, IDLE->BRK on F0, EXT->EXT_BRK on F0; any other byte completes a make (IDLE/EXT) or break (BRK/EXT_BRK) and returns to IDLE.
REQ-015 SHALL decode makes: 0x5A drop, 0x29 colsel, 0x66 newgame, 0x16/0x1E/0x26/0x25/0x2E/0x36/0x3D set cursor to 0..6, E0 0x6B cursor-1, E0 0x74 cursor+1; all other codes ignored without error.
REQ-016 SHALL assert each pulse output exactly one cycle, in the cycle after the completing byte's strobe (latency 1).
REQ-017 SHALL saturate cursor at 0 on left and at NUM_COLS-1 on right; direct-select codes at or beyond NUM_COLS are ignored.
REQ-018 SHALL update cursor and column_onehot in the same cycle the corresponding pulse would appear.
REQ-019 SHALL keep a held flag per decoded key, set on make and cleared on matching break; a make for a key whose flag is set (typematic repeat) produces no pulse and no cursor change.
REQ-020 SHALL treat non-extended and extended codes as distinct keys (0x6B alone is not left-arrow).
REQ-021 SHALL return to IDLE if a prefix state lasts PREFIX_TIMEOUT cycles with no strobe, discarding the prefix.
REQ-022 SHALL ignore 0xE1 (Pause) and 0xAA/0xFA/0xEE controller responses in IDLE, staying in IDLE.
REQ-023 SHALL never assert two pulse outputs in the same cycle.

Reset
REQ-024 SHALL, on reset assertion, immediately clear FSM to IDLE, all pulses to 0, all held flags and key_held to 0, cursor to 0, column_onehot to 8'h01, timeout counter to 0.
REQ-025 SHALL ignore a strobe coincident with reset deassertion edge cycle only if reset is still high at that clock edge.

Configuration
REQ-026 SHALL honour macro PS2_TYPEMATIC_ARROWS_EN: when defined, repeated left/right makes while held each move the cursor (other keys still suppressed); when undefined, REQ-019 applies to all keys.

Structure
REQ-027 SHALL place scan-code constants, FSM state encoding and key index enumeration in shared package connect4_pkg.
REQ-028 SHALL implement the prefix timeout as sub-module prefix_timer (load, count, expire output).

Verification
REQ-029 SHALL test: strobes 0x5A, F0, 0x5A -> drop_pulse high exactly one cycle after first strobe, none after break.
REQ-030 SHALL test: cursor=6, strobes E0,0x74,E0,F0,0x74 -> cursor stays 6, no pulse, key_held 1 then 0.
REQ-031 SHALL test: strobes 0x26,0x26,0x26 (no break) -> cursor=2 once, column_onehot=8'h04; with PS2_TYPEMATIC_ARROWS_EN E0,0x6B x3 from cursor 4 -> cursor 1.
REQ-032 SHALL test: strobe F0 then idle PREFIX_TIMEOUT cycles, then 0x29 -> colsel_pulse asserted (prefix discarded).
REQ-033 SHALL test: reset asserted while in EXT_BRK with cursor=5 -> outputs immediately reset values; next 0x66 -> newgame_pulse.

Source files
------------

// File: rtl/connect4_pkg.sv
// rtl/connect4_pkg.sv - scan codes, parser states and key indices shared by the PS/2 command decoder
package connect4_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_COL0  = 8'h16;
    localparam logic [7:0] SC_COL1  = 8'h1E;
    localparam logic [7:0] SC_COL2  = 8'h26;
    localparam logic [7:0] SC_COL3  = 8'h25;
    localparam logic [7:0] SC_COL4  = 8'h2E;
    localparam logic [7:0] SC_COL5  = 8'h36;
    localparam logic [7:0] SC_COL6  = 8'h3D;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } parse_state_t;

    typedef enum logic [3:0] {
        KEY_DROP    = 4'd0,
        KEY_COLSEL  = 4'd1,
        KEY_NEWGAME = 4'd2,
        KEY_COL0    = 4'd3,
        KEY_COL1    = 4'd4,
        KEY_COL2    = 4'd5,
        KEY_COL3    = 4'd6,
        KEY_COL4    = 4'd7,
        KEY_COL5    = 4'd8,
        KEY_COL6    = 4'd9,
        KEY_LEFT    = 4'd10,
        KEY_RIGHT   = 4'd11,
        KEY_NONE    = 4'd15
    } key_t;

    // Extended and plain codes map to distinct keys; unknown codes map to KEY_NONE.
    function automatic key_t decode_key(input logic ext, input logic [7:0] code);
        key_t k;
        k = KEY_NONE;
        if (ext) begin
            case (code)
                SC_LEFT:  k = KEY_LEFT;
                SC_RIGHT: k = KEY_RIGHT;
                default:  k = KEY_NONE;
            endcase
        end else begin
            case (code)
                SC_ENTER: k = KEY_DROP;
                SC_SPACE: k = KEY_COLSEL;
                SC_BKSP:  k = KEY_NEWGAME;
                SC_COL0:  k = KEY_COL0;
                SC_COL1:  k = KEY_COL1;
                SC_COL2:  k = KEY_COL2;
                SC_COL3:  k = KEY_COL3;
                SC_COL4:  k = KEY_COL4;
                SC_COL5:  k = KEY_COL5;
                SC_COL6:  k = KEY_COL6;
                default:  k = KEY_NONE;
            endcase
        end
        return k;
    endfunction

    function automatic logic [2:0] key_column(input key_t k);
        logic [3:0] d;
        d = 4'(k) - 4'(KEY_COL0);
        return d[2:0];
    endfunction

endpackage

// File: rtl/prefix_timer.sv
// rtl/prefix_timer.sv - counts idle cycles of a pending E0/F0 prefix and flags expiry
module prefix_timer #(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Expiry fires on the TIMEOUT-th consecutive counting cycle.
    assign expire = count && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load || expire) begin
            cnt <= '0;
        end else if (count) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_command_decoder.sv
// rtl/ps2_command_decoder.sv - PS/2 scan-code parser to game commands; PS2_TYPEMATIC_ARROWS_EN lets held arrows repeat
module ps2_command_decoder
    import connect4_pkg::*;
#(
    parameter int NUM_COLS       = 7,
    parameter int PREFIX_TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic       drop_pulse,
    output logic       colsel_pulse,
    output logic       newgame_pulse,
    output logic [2:0] cursor,
    output logic [7:0] column_onehot,
    output logic       key_held
);

    localparam logic [2:0] LAST_COL = 3'(NUM_COLS - 1);

    parse_state_t state;
    logic [15:0]  held;
    logic [15:0]  next_held;
    logic         in_ext;
    logic         in_brk;
    logic         is_prefix_byte;
    logic         completes;
    logic         repeat_ok;
    logic         make_ok;
    logic         expire;
    key_t         key;
    logic [2:0]   col;
    logic [2:0]   next_cursor;
    logic         fire_drop;
    logic         fire_colsel;
    logic         fire_newgame;

    assign in_ext = (state == ST_EXT) || (state == ST_EXT_BRK);
    assign in_brk = (state == ST_BRK) || (state == ST_EXT_BRK);
    assign is_prefix_byte = ((state == ST_IDLE) && ((received_data == SC_EXT) || (received_data == SC_BRK)))
                         || ((state == ST_EXT) && (received_data == SC_BRK));
    assign completes = received_data_en && !is_prefix_byte;
    assign key = decode_key(in_ext, received_data);
    assign col = key_column(key);

`ifdef PS2_TYPEMATIC_ARROWS_EN
    assign repeat_ok = (key == KEY_LEFT) || (key == KEY_RIGHT);
`else
    assign repeat_ok = 1'b0;
`endif

    // A make acts only on the first press unless the key may auto-repeat.
    assign make_ok = completes && !in_brk && (key != KEY_NONE) && (!held[key] || repeat_ok);

    prefix_timer #(.TIMEOUT(PREFIX_TIMEOUT)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (received_data_en),
        .count  ((state != ST_IDLE) && !received_data_en),
        .expire (expire)
    );

    always_comb begin
        next_cursor  = cursor;
        next_held    = held;
        fire_drop    = 1'b0;
        fire_colsel  = 1'b0;
        fire_newgame = 1'b0;
        if (completes && (key != KEY_NONE)) begin
            next_held[key] = !in_brk;
        end
        if (make_ok) begin
            case (key)
                KEY_DROP:    fire_drop    = 1'b1;
                KEY_COLSEL:  fire_colsel  = 1'b1;
                KEY_NEWGAME: fire_newgame = 1'b1;
                KEY_LEFT:    if (cursor != 3'd0) next_cursor = cursor - 3'd1;
                KEY_RIGHT:   if (cursor < LAST_COL) next_cursor = cursor + 3'd1;
                KEY_COL0, KEY_COL1, KEY_COL2, KEY_COL3,
                KEY_COL4, KEY_COL5, KEY_COL6: begin
                    if (col <= LAST_COL) next_cursor = col;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            held          <= '0;
            key_held      <= 1'b0;
            cursor        <= 3'd0;
            column_onehot <= 8'h01;
            drop_pulse    <= 1'b0;
            colsel_pulse  <= 1'b0;
            newgame_pulse <= 1'b0;
        end else begin
            drop_pulse    <= fire_drop;
            colsel_pulse  <= fire_colsel;
            newgame_pulse <= fire_newgame;
            cursor        <= next_cursor;
            column_onehot <= 8'h01 << next_cursor;
            held          <= next_held;
            key_held      <= |next_held;
            if (received_data_en) begin
                case (state)
                    ST_IDLE: begin
                        if (received_data == SC_EXT)      state <= ST_EXT;
                        else if (received_data == SC_BRK) state <= ST_BRK;
                        else                              state <= ST_IDLE;
                    end
                    ST_EXT:  state <= (received_data == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end else if (expire) begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ps2_command_decoder.sv
// tb/tb_ps2_command_decoder.sv - directed and random scan-code streams checked against a byte-level keyboard model
module tb_ps2_command_decoder;

    localparam int P  = 16;
    localparam int NC = 7;
`ifdef PS2_TYPEMATIC_ARROWS_EN
    localparam bit TYPEMATIC = 1'b1;
`else
    localparam bit TYPEMATIC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] received_data = 8'h00;
    logic       received_data_en = 1'b0;
    logic       drop_pulse, colsel_pulse, newgame_pulse, key_held;
    logic [2:0] cursor;
    logic [7:0] column_onehot;

    ps2_command_decoder #(.NUM_COLS(NC), .PREFIX_TIMEOUT(P)) dut (
        .clk              (clk),
        .reset            (reset),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .drop_pulse       (drop_pulse),
        .colsel_pulse     (colsel_pulse),
        .newgame_pulse    (newgame_pulse),
        .cursor           (cursor),
        .column_onehot    (column_onehot),
        .key_held         (key_held)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Keyboard model: pending prefix flags, idle age of the prefix, per-code held table.
    logic [7:0] col_codes [7] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D};
    logic [7:0] pool [20] = '{8'hE0, 8'hF0, 8'hF0, 8'h5A, 8'h29, 8'h66, 8'h16, 8'h1E, 8'h26, 8'h25,
                              8'h2E, 8'h36, 8'h3D, 8'h6B, 8'h74, 8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hE0};
    int m_cursor;
    bit m_ext, m_brk;
    int m_idle;
    bit m_held [512];
    bit e_drop, e_colsel, e_newgame;

    function automatic int act_of(bit ext, logic [7:0] c);
        if (ext) return (c == 8'h6B) ? 20 : (c == 8'h74) ? 21 : 0;
        if (c == 8'h5A) return 1;
        if (c == 8'h29) return 2;
        if (c == 8'h66) return 3;
        for (int i = 0; i < 7; i++) if (c == col_codes[i]) return 10 + i;
        return 0;
    endfunction

    task automatic model_reset();
        m_cursor = 0; m_ext = 0; m_brk = 0; m_idle = 0;
        for (int i = 0; i < 512; i++) m_held[i] = 0;
        e_drop = 0; e_colsel = 0; e_newgame = 0;
    endtask

    task automatic perform(input int a);
        if (a == 1) e_drop = 1;
        else if (a == 2) e_colsel = 1;
        else if (a == 3) e_newgame = 1;
        else if (a == 20) m_cursor = (m_cursor > 0) ? m_cursor - 1 : 0;
        else if (a == 21) m_cursor = (m_cursor < NC - 1) ? m_cursor + 1 : NC - 1;
        else if (a >= 10 && a < 10 + NC) m_cursor = a - 10;
    endtask

    task automatic model_apply(input bit v, input logic [7:0] b);
        int a, k;
        bit rep;
        e_drop = 0; e_colsel = 0; e_newgame = 0;
        if (!v) begin
            if (m_ext || m_brk) begin
                m_idle++;
                if (m_idle >= P) begin m_ext = 0; m_brk = 0; end
            end
            return;
        end
        m_idle = 0;
        if (!m_ext && !m_brk && b == 8'hE0) m_ext = 1;
        else if (!m_brk && b == 8'hF0) m_brk = 1;
        else begin
            a = act_of(m_ext, b);
            k = m_ext ? 256 + int'(b) : int'(b);
            if (a != 0) begin
                if (m_brk) m_held[k] = 0;
                else begin
                    rep = m_held[k];
                    m_held[k] = 1;
                    if (!rep || (TYPEMATIC && (a == 20 || a == 21))) perform(a);
                end
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    function automatic bit any_held();
        for (int i = 0; i < 512; i++) if (m_held[i]) return 1;
        return 0;
    endfunction

    task automatic compare_all();
        logic [7:0] oh;
        oh = 8'h01 << m_cursor;
        check("drop_pulse", drop_pulse, e_drop);
        check("colsel_pulse", colsel_pulse, e_colsel);
        check("newgame_pulse", newgame_pulse, e_newgame);
        check("cursor", cursor, m_cursor);
        check("column_onehot", column_onehot, oh);
        check("key_held", key_held, any_held());
        check("single_pulse", (int'(drop_pulse) + int'(colsel_pulse) + int'(newgame_pulse)) <= 1, 1);
    endtask

    task automatic step(input bit v, input logic [7:0] b);
        @(negedge clk);
        received_data_en = v;
        received_data = v ? b : 8'($urandom);
        model_apply(v, b);
        @(posedge clk);
        #1;
        received_data_en = 0;
        compare_all();
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00);
    endtask

    int r;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_cursor", cursor, 0);
        check("rst_onehot", column_onehot, 8'h01);
        check("rst_key_held", key_held, 0);
        check("rst_pulses", {drop_pulse, colsel_pulse, newgame_pulse}, 0);
        @(negedge clk);
        reset = 0;

        // Enter make then break
        send(8'h5A);
        check("t_drop_make", drop_pulse, 1);
        send(8'hF0);
        check("t_drop_once", drop_pulse, 0);
        send(8'h5A);
        check("t_drop_break", drop_pulse, 0);
        idle(2);

        // Right arrow at the right edge
        send(8'h3D); send(8'hF0); send(8'h3D);
        send(8'hE0); send(8'h74);
        check("t_right_sat", cursor, 6);
        check("t_right_held", key_held, 1);
        send(8'hE0); send(8'hF0); send(8'h74);
        check("t_right_rel", key_held, 0);
        check("t_right_final", cursor, 6);

        // Repeated direct select without break
        send(8'h26); send(8'h26); send(8'h26);
        check("t_col2", cursor, 2);
        check("t_col2_onehot", column_onehot, 8'h04);
        send(8'hF0); send(8'h26);
        send(8'h2E); send(8'hF0); send(8'h2E);
        send(8'hE0); send(8'h6B); send(8'hE0); send(8'h6B); send(8'hE0); send(8'h6B);
        if (TYPEMATIC) check("t_left_typematic", cursor, 1);
        else           check("t_left_repeat", cursor, 3);
        send(8'hE0); send(8'hF0); send(8'h6B);
        send(8'h6B);
        check("t_plain_6b", cursor, TYPEMATIC ? 1 : 3);

        // Prefix timeout and its boundary
        send(8'hF0); idle(P); send(8'h29);
        check("t_timeout_colsel", colsel_pulse, 1);
        send(8'hF0); idle(P - 1); send(8'h29);
        check("t_pending_break", colsel_pulse, 0);
        idle(1);

        // Reset while in EXT_BRK with cursor at 5
        send(8'h36); send(8'hF0); send(8'h36);
        send(8'h5A);
        send(8'hE0); send(8'hF0);
        check("t_pre_rst_cursor", cursor, 5);
        #2;
        reset = 1;
        #1;
        model_reset();
        check("t_rst_cursor", cursor, 0);
        check("t_rst_onehot", column_onehot, 8'h01);
        check("t_rst_key_held", key_held, 0);
        check("t_rst_pulses", {drop_pulse, colsel_pulse, newgame_pulse}, 0);
        @(negedge clk);
        reset = 0;
        send(8'h66);
        check("t_newgame", newgame_pulse, 1);
        idle(1);

        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) idle($urandom_range(P - 2, P + 1));
            else if (r == 1) idle($urandom_range(1, 3));
            else if (r == 2) send(8'($urandom));
            else send(pool[$urandom_range(0, 19)]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
